// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, NOP encoding and reset PC for the fetch stage
package fetch_stage_pkg;

  localparam int DEF_WORD_LEN = 32;
  localparam int DEF_IMEM_DEPTH = 1024;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Word-index width of the instruction memory; a one-word memory still needs one bit.
  function automatic int imemAddrBits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word array with asynchronous read and synchronous write
module instruction_memory
  import fetch_stage_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  localparam int ADDR_W = imemAddrBits(IMEM_DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WORD_LEN-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [WORD_LEN-1:0] rdata
);

  logic [WORD_LEN-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write returns the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, branch redirect and IF/ID pipeline register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter logic [WORD_LEN-1:0] RESET_PC = WORD_LEN'(DEF_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_offset,
  input  logic                imem_we,
  input  logic [WORD_LEN-1:0] imem_waddr,
  input  logic [WORD_LEN-1:0] imem_wdata,
  output logic [WORD_LEN-1:0] if_pc,
  output logic [WORD_LEN-1:0] id_pc_plus4,
  output logic [WORD_LEN-1:0] id_instr,
  output logic                id_valid
);

  localparam int ADDR_W = imemAddrBits(IMEM_DEPTH);
  localparam logic [WORD_LEN-1:0] RESET_PC_ALIGNED = {RESET_PC[WORD_LEN-1:2], 2'b00};

  logic [WORD_LEN-1:0] fetchWord;
  logic [WORD_LEN-1:0] pcPlus4;
  logic [WORD_LEN-1:0] brTarget;
  logic                unusedWaddrBits;

  assign pcPlus4  = if_pc + WORD_LEN'(4);
  assign brTarget = id_pc_plus4 + (br_offset << 2);

  // Byte-offset and above-depth address bits do not select a word.
  assign unusedWaddrBits = ^{imem_waddr[WORD_LEN-1:ADDR_W+2], imem_waddr[1:0]};

  instruction_memory #(
    .WORD_LEN  (WORD_LEN),
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_imem (
    .clk  (clk),
    .we   (imem_we),
    .waddr(imem_waddr[ADDR_W+1:2]),
    .wdata(imem_wdata),
    .raddr(if_pc[ADDR_W+1:2]),
    .rdata(fetchWord)
  );

  // Freeze outranks a branch because the ID operands feeding br_taken are stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc       <= RESET_PC_ALIGNED;
      id_instr    <= WORD_LEN'(NOP_INSTR);
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (!freeze) begin
      if (br_taken) begin
        if_pc       <= brTarget;
        id_instr    <= WORD_LEN'(NOP_INSTR);
        id_pc_plus4 <= '0;
        id_valid    <= 1'b0;
      end else begin
        if_pc       <= pcPlus4;
        id_instr    <= fetchWord;
        id_pc_plus4 <= pcPlus4;
        id_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven and randomized self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] if_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_valid;

  int compared;
  int mismatched;

  fetch_stage #(
    .WORD_LEN  (32),
    .IMEM_DEPTH(DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .if_pc      (if_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_instr   (id_instr),
    .id_valid   (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural view of PC, IF/ID contents and memory.
  logic [31:0] mMem [DEPTH];
  logic [31:0] mPc;
  logic [31:0] mPc4;
  logic [31:0] mInstr;
  logic        mValid;

  typedef struct {
    bit          r;
    bit          f;
    bit          b;
    logic [31:0] off;
    bit          we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    bit          valid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge();
    logic [31:0] fetched;
    fetched = mMem[int'((mPc / 4) % DEPTH)];
    if (rst) begin
      mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
    end else if (freeze) begin
      // everything holds
    end else if (br_taken) begin
      mPc = mPc4 + br_offset * 4; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
    end else begin
      mInstr = fetched; mPc = mPc + 4; mPc4 = mPc; mValid = 1'b1;
    end
    if (imem_we) mMem[int'((imem_waddr / 4) % DEPTH)] = imem_wdata;
  endtask

  task automatic step(input bit r, input bit f, input bit b, input logic [31:0] off,
                      input bit we, input logic [31:0] wa, input logic [31:0] wd);
    rst = r; freeze = f; br_taken = b; br_offset = off;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    if (b) check("br_legal", {31'b0, id_valid}, 32'h1);
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit r, input bit f, input bit b, input logic [31:0] off,
                              input bit we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input bit valid);
    vec_t v;
    v.r = r; v.f = f; v.b = b; v.off = off; v.we = we; v.wa = wa; v.wd = wd;
    v.pc = pc; v.instr = instr; v.pc4 = pc4; v.valid = valid;
    return v;
  endfunction

  initial begin
    compared = 0;
    mismatched = 0;

    // Directed sequence; memory holds (i+1)*0x11 at word i after the loader.
    vecs.push_back(mk(1,0,0,0,          0,0,0,     32'h00, 32'h00,  32'h00, 0)); // reset state
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h04, 32'h11,  32'h04, 1));
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h08, 32'h22,  32'h08, 1));
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h0C, 32'h33,  32'h0C, 1));
    vecs.push_back(mk(0,0,1,3,          0,0,0,     32'h18, 32'h00,  32'h00, 0)); // taken branch
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h1C, 32'h77,  32'h1C, 1));
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h20, 32'h88,  32'h20, 1));
    vecs.push_back(mk(0,0,1,32'hFFFFFFFC,0,0,0,    32'h10, 32'h00,  32'h00, 0)); // negative offset
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h14, 32'h55,  32'h14, 1));
    vecs.push_back(mk(0,1,1,1,          0,0,0,     32'h14, 32'h55,  32'h14, 1)); // freeze beats branch
    vecs.push_back(mk(0,1,1,1,          0,0,0,     32'h14, 32'h55,  32'h14, 1));
    vecs.push_back(mk(0,1,1,1,          0,0,0,     32'h14, 32'h55,  32'h14, 1));
    vecs.push_back(mk(0,0,1,1,          0,0,0,     32'h18, 32'h00,  32'h00, 0)); // held branch resolves
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h1C, 32'h77,  32'h1C, 1));
    vecs.push_back(mk(0,0,1,8,          0,0,0,     32'h3C, 32'h00,  32'h00, 0));
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h40, 32'h110, 32'h40, 1));
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h44, 32'h11,  32'h44, 1)); // 0x40 wraps to word 0
    vecs.push_back(mk(0,0,1,32'hFFFFFFEE,0,0,0,    32'hFFFFFFFC, 32'h00, 32'h00, 0));
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h00, 32'h110, 32'h00, 1)); // PC wraps to 0
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h04, 32'h11,  32'h04, 1));
    vecs.push_back(mk(1,0,1,5,          0,0,0,     32'h00, 32'h00,  32'h00, 0)); // reset beats branch
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h04, 32'h11,  32'h04, 1));
    vecs.push_back(mk(0,0,0,0,          1,32'h08,32'h55, 32'h08, 32'h22, 32'h08, 1));
    vecs.push_back(mk(0,0,0,0,          1,32'h08,32'hAB, 32'h0C, 32'h55, 32'h0C, 1)); // old word on collision
    vecs.push_back(mk(0,0,1,32'hFFFFFFFF,0,0,0,    32'h08, 32'h00,  32'h00, 0));
    vecs.push_back(mk(0,0,0,0,          0,0,0,     32'h0C, 32'hAB,  32'h0C, 1)); // refetch sees new word

    // Loader runs under reset.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 32'h0, 1, 32'(i * 4), 32'((i + 1) * 32'h11));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].f, vecs[i].b, vecs[i].off, vecs[i].we, vecs[i].wa, vecs[i].wd);
      check($sformatf("v%0d_if_pc", i), if_pc, vecs[i].pc);
      check($sformatf("v%0d_id_instr", i), id_instr, vecs[i].instr);
      check($sformatf("v%0d_id_pc_plus4", i), id_pc_plus4, vecs[i].pc4);
      check($sformatf("v%0d_id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].valid});
    end

    // Reset asserted during a freeze still wins, then fetch restarts at word 0.
    step(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    check("rst_freeze_pc", if_pc, 32'h0);
    check("rst_freeze_valid", {31'b0, id_valid}, 32'h0);
    step(0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    check("post_rst_instr", id_instr, 32'h11);
    check("post_rst_pc", if_pc, 32'h4);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      bit r, f, b, we;
      logic [31:0] off;
      r   = ($urandom_range(0, 49) == 0);
      f   = ($urandom_range(0, 4) == 0);
      b   = mValid && ($urandom_range(0, 3) == 0);
      off = 32'($signed($urandom_range(0, 16)) - 8);
      we  = ($urandom_range(0, 5) == 0);
      step(r, f, b, off, we, $urandom, $urandom);
      check("rnd_if_pc", if_pc, mPc);
      check("rnd_id_instr", id_instr, mInstr);
      check("rnd_id_pc_plus4", id_pc_plus4, mPc4);
      check("rnd_id_valid", {31'b0, id_valid}, {31'b0, mValid});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
